// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF stage with imem req/ack handshake, stall hold and redirect drain into IF/ID.
module fetch_unit #(
    parameter logic [6:0] RESET_PC = 7'h00
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [6:0]  i_redirect_pc,
    output logic        o_imem_req,
    output logic [6:0]  o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [6:0]  o_pc4_out,
    output logic [31:0] o_instr_out,
    output logic        o_ifid_flush
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    state_t      r_state, w_next;
    logic [6:0]  r_pc, r_old_pc, w_pc4, w_target, w_next_pc;
    logic [31:0] r_buf;
    logic        w_deliver;

    assign w_pc4     = r_pc + 7'd4;
    assign w_target  = {i_redirect_pc[6:2], 2'b00};
    assign w_deliver = i_rst_n & ~i_redirect & ~i_stall &
                       ((r_state == HOLD) | ((r_state == FETCH) & i_imem_ack));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_old_pc <= RESET_PC;
            r_buf    <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_next_pc;
            // DRAIN keeps presenting the abandoned address until its ack arrives
            if (r_state == FETCH && !i_imem_ack && i_redirect)
                r_old_pc <= r_pc;
            if (r_state == FETCH && i_imem_ack && !i_redirect && i_stall)
                r_buf <= i_imem_rdata;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_next_pc = i_redirect ? w_target : (w_deliver ? w_pc4 : r_pc);
        case (r_state)
            FETCH:   w_next = i_redirect ? (i_imem_ack ? FETCH : DRAIN)
                                         : ((i_imem_ack && i_stall) ? HOLD : FETCH);
            HOLD:    w_next = (i_redirect || !i_stall) ? FETCH : HOLD;
            DRAIN:   w_next = i_imem_ack ? FETCH : DRAIN;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        o_imem_req   = i_rst_n && (r_state != HOLD);
        o_imem_addr  = (r_state == DRAIN) ? r_old_pc : r_pc;
        o_instr_out  = w_deliver ? ((r_state == HOLD) ? r_buf : i_imem_rdata) : 32'h0;
        o_pc4_out    = w_deliver ? w_pc4 : 7'h0;
        o_ifid_flush = ~i_rst_n | i_redirect | (~i_stall & ~w_deliver);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a queue-free behavioural fetch model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
    logic [6:0]  redirect_pc = 7'h0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, ifid_flush;
    logic [6:0]  imem_addr, pc4_out;
    logic [31:0] instr_out;
    logic [31:0] salt;
    int          checks = 0, errors = 0;

    fetch_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .o_pc4_out(pc4_out),
        .o_instr_out(instr_out), .o_ifid_flush(ifid_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [6:0] a);
        return salt ^ {a, 25'h0} ^ {25'h0, a} ^ 32'h1357_9BDF;
    endfunction

    // inputs change on the falling edge; outputs are then sampled 1 time unit later
    task automatic drive(input logic s, input logic r, input logic [6:0] rp, input logic a, input logic [31:0] d);
        @(negedge clk);
        rst_n = 1'b1; stall = s; redirect = r; redirect_pc = rp; imem_ack = a; imem_rdata = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL rst_flush got %b exp 1", ifid_flush); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr_out); end
        checks++; if (pc4_out !== 7'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", pc4_out); end
        drive(0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 7'h0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, memf(7'(4 * i)));
            checks++; if (imem_addr !== 7'(4 * i)) begin errors++; $display("FAIL stream_addr got %h exp %h", imem_addr, 7'(4 * i)); end
            checks++; if (pc4_out !== 7'(4 * i + 4)) begin errors++; $display("FAIL stream_pc4 got %h exp %h", pc4_out, 7'(4 * i + 4)); end
            checks++; if (instr_out !== memf(7'(4 * i))) begin errors++; $display("FAIL stream_instr got %h exp %h", instr_out, memf(7'(4 * i))); end
            checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL stream_flush got %b exp 0", ifid_flush); end
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            repeat (2) begin
                drive(0, 0, 0, 0, 32'h0);
                checks++; if (imem_addr !== 7'(4 * k) || imem_req !== 1'b1) begin errors++; $display("FAIL lat_wait_addr got %h/%b exp %h/1", imem_addr, imem_req, 7'(4 * k)); end
                checks++; if (ifid_flush !== 1'b1 || instr_out !== 32'h0) begin errors++; $display("FAIL lat_wait_bubble got %b/%h exp 1/0", ifid_flush, instr_out); end
            end
            drive(0, 0, 0, 1, memf(7'(4 * k)));
            checks++; if (instr_out !== memf(7'(4 * k)) || pc4_out !== 7'(4 * k + 4) || ifid_flush !== 1'b0) begin
                errors++; $display("FAIL lat_deliver got %h/%h/%b exp %h/%h/0", instr_out, pc4_out, ifid_flush, memf(7'(4 * k)), 7'(4 * k + 4)); end
        end
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b exp 0", imem_req); end
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (imem_addr !== 7'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL midrst_addr got %h/%b exp 00/1", imem_addr, imem_req); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 0, 0, 1, memf(7'h0));
        drive(0, 0, 0, 1, memf(7'h4));
        drive(1, 0, 0, 1, 32'hDEAD_BEEF);
        checks++; if (ifid_flush !== 1'b0 || imem_addr !== 7'h8) begin errors++; $display("FAIL stall_ack got %b/%h exp 0/08", ifid_flush, imem_addr); end
        repeat (2) begin
            drive(1, 0, 0, 0, 32'h0);
            checks++; if (imem_req !== 1'b0 || ifid_flush !== 1'b0) begin errors++; $display("FAIL stall_hold got %b/%b exp 0/0", imem_req, ifid_flush); end
        end
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (pc4_out !== 7'd12 || instr_out !== 32'hDEAD_BEEF || ifid_flush !== 1'b0) begin
            errors++; $display("FAIL stall_release got %h/%h/%b exp 0c/deadbeef/0", pc4_out, instr_out, ifid_flush); end
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (imem_addr !== 7'd12 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_next got %h/%b exp 0c/1", imem_addr, imem_req); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, memf(7'(4 * i)));
        drive(0, 1, 7'h40, 0, 32'h0);
        checks++; if (ifid_flush !== 1'b1 || imem_addr !== 7'd16) begin errors++; $display("FAIL redir_cycle got %b/%h exp 1/10", ifid_flush, imem_addr); end
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (imem_addr !== 7'd16 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_drain got %h/%b exp 10/1", imem_addr, imem_req); end
        drive(0, 0, 0, 1, memf(7'd16));
        checks++; if (imem_addr !== 7'd16 || instr_out !== 32'h0 || ifid_flush !== 1'b1) begin
            errors++; $display("FAIL redir_discard got %h/%h/%b exp 10/0/1", imem_addr, instr_out, ifid_flush); end
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (imem_addr !== 7'h40) begin errors++; $display("FAIL redir_target got %h exp 40", imem_addr); end
    endtask

    task automatic test_hold_redirect();
        do_reset();
        drive(1, 0, 0, 1, memf(7'h0));
        drive(1, 1, 7'h7F, 0, 32'h0);
        checks++; if (ifid_flush !== 1'b1 || instr_out !== 32'h0) begin errors++; $display("FAIL hold_redir got %b/%h exp 1/0", ifid_flush, instr_out); end
        drive(0, 0, 0, 1, memf(7'h7C));
        checks++; if (imem_addr !== 7'h7C || imem_req !== 1'b1) begin errors++; $display("FAIL hold_target got %h/%b exp 7c/1", imem_addr, imem_req); end
        checks++; if (pc4_out !== 7'h00 || instr_out !== memf(7'h7C) || ifid_flush !== 1'b0) begin
            errors++; $display("FAIL wrap_deliver got %h/%h/%b exp 00/%h/0", pc4_out, instr_out, ifid_flush, memf(7'h7C)); end
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (imem_addr !== 7'h00) begin errors++; $display("FAIL wrap_next got %h exp 00", imem_addr); end
    endtask

    task automatic test_random();
        logic [6:0]  m_pc = 7'h0, m_waddr = 7'h0, e_addr, e_pc4, rp;
        logic [31:0] m_hinstr = 32'h0, d, e_instr;
        logic        m_held = 1'b0, m_wrong = 1'b0, s, r, a, dlv, e_flush;
        int          wl = -1;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            e_addr = m_wrong ? m_waddr : m_pc;
            a = 1'b0;
            if (!m_held) begin
                if (wl < 0) wl = $urandom_range(0, 2);
                a = (wl == 0);
                wl = a ? -1 : wl - 1;
            end
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 9) < 1);
            rp = 7'($urandom);
            d = memf(e_addr);
            drive(s, r, rp, a, d);
            dlv = !r && !s && (m_held || (a && !m_wrong));
            e_instr = dlv ? (m_held ? m_hinstr : d) : 32'h0;
            e_pc4 = dlv ? m_pc + 7'd4 : 7'h0;
            e_flush = r | (!s & !dlv);
            checks++; if (imem_req !== !m_held) begin errors++; $display("FAIL rnd_req c=%0d got %b exp %b", c, imem_req, !m_held); end
            checks++; if (!m_held && imem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, imem_addr, e_addr); end
            checks++; if (instr_out !== e_instr) begin errors++; $display("FAIL rnd_instr c=%0d got %h exp %h", c, instr_out, e_instr); end
            checks++; if (pc4_out !== e_pc4) begin errors++; $display("FAIL rnd_pc4 c=%0d got %h exp %h", c, pc4_out, e_pc4); end
            checks++; if (ifid_flush !== e_flush) begin errors++; $display("FAIL rnd_flush c=%0d got %b exp %b", c, ifid_flush, e_flush); end
            if (r) begin
                if (m_held) m_held = 1'b0;
                else if (!m_wrong && !a) begin m_wrong = 1'b1; m_waddr = m_pc; end
                else if (m_wrong && a) m_wrong = 1'b0;
                m_pc = {rp[6:2], 2'b00};
            end else if (m_wrong) begin
                if (a) m_wrong = 1'b0;
            end else if (dlv) begin
                m_held = 1'b0; m_pc = m_pc + 7'd4;
            end else if (a && s) begin
                m_held = 1'b1; m_hinstr = d;
            end
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_stream();
        test_latency();
        test_stall();
        test_redirect();
        test_hold_redirect();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage driving the IF/ID pipeline register: owns the 7-bit PC, runs a request/acknowledge handshake to instruction memory and delivers {PC+4, instruction} into IF/ID. It generates the IF/ID flush (bubble or squash), honours the ID-stage stall, and handles branch/jump redirects, including redirects that arrive while a memory request is outstanding.

## Interface
- RESET_PC, 7'h00, PC loaded on reset; bits [1:0] must be 0
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- stall  input  1  hazard unit holds IF/ID this cycle; same signal drives IF/ID hold
- redirect  input  1  taken branch/jump resolved this cycle
- redirect_pc  input  7  redirect target; bits [1:0] forced to 0 internally
- imem_req  output  1  instruction memory request
- imem_addr  output  7  request address, equals PC
- imem_ack  input  1  one-cycle acknowledge; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- pc4_out  output  7  to IF/ID PC4in
- instr_out  output  32  to IF/ID Iin
- ifid_flush  output  1  to IF/ID flush

## Operation
- Registers: pc[6:0], state, buffer buf_instr[31:0].
- States: FETCH (request outstanding), HOLD (instruction buffered, waiting for stall release), DRAIN (request outstanding for discarded wrong-path fetch).
- FETCH: imem_req=1, imem_addr=pc. On imem_ack:
  - redirect=1: discard data; pc<=redirect_pc; stay FETCH.
  - stall=0: deliver (instr_out=imem_rdata, pc4_out=pc+4); pc<=pc+4; stay FETCH.
  - stall=1: buf_instr<=imem_rdata; go HOLD.
- FETCH without ack: redirect=1 -> pc<=redirect_pc, go DRAIN; else wait.
- HOLD: imem_req=0. redirect=1 -> pc<=redirect_pc, go FETCH, buffer dropped. stall=0 -> deliver buf_instr with pc+4, pc<=pc+4, go FETCH. stall=1 -> stay.
- DRAIN: imem_req=1, imem_addr = old pc held in a separate register (address stable until ack); pc already holds target. On ack: discard, go FETCH. New redirect in DRAIN: overwrite pc, stay DRAIN.
- Address held stable and imem_req never dropped while a request is outstanding; requests are never withdrawn.
- ifid_flush = redirect | (~stall & ~deliver). Never asserted while stall=1 and redirect=0 (IF/ID flush overrides hold; held instruction must survive).
- When not delivering: instr_out=32'h0 (NOP), pc4_out=7'h0.
- Arithmetic: pc+4 is 7-bit modulo 128; 7'h7C+4 -> 7'h00, no carry out.
- Priority: rst_n > redirect > stall > delivery.

## Timing
- Reset (rst_n=0 at edge): pc<=RESET_PC, state<=FETCH, internal buffer cleared. While rst_n=0: imem_req=0, ifid_flush=1, instr_out=0, pc4_out=0.
- First imem_req in the first cycle with rst_n=1.
- Zero-wait memory (ack in request cycle): one instruction delivered per cycle; IF/ID captures it at that edge.
- Delivery combinational from imem_rdata/buffer in the delivery cycle; PC updates at the same edge.
- Redirect takes effect next cycle: first request to target issued next cycle (FETCH) or after drain ack (DRAIN).
- Reset mid-request: outstanding request abandoned; memory must tolerate the drop.

## Test plan
- Reset, RESET_PC=0, ack every cycle, stall=0: imem_addr 0,4,8,...; pc4_out 4,8,12 with matching instr; ifid_flush=0 after reset.
- Ack latency 2 cycles: ifid_flush=1 with instr_out=0 on non-ack cycles, delivery on ack cycle only; address stable during wait.
- Stall=1 for 3 cycles on ack of addr 8 (data 32'hDEADBEEF): imem_req=0, ifid_flush=0 throughout; at release pc4_out=12, instr_out=32'hDEADBEEF, next request addr 12.
- Redirect to 7'h40 while fetch of addr 16 outstanding: ifid_flush=1 that cycle, imem_addr stays 16 until ack, data discarded, next request addr 0x40.
- Redirect with simultaneous stall in HOLD: buffer dropped, ifid_flush=1, next request addr = target; wrap-around fetch at 7'h7C delivers pc4_out=7'h00.
